// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and next-PC source select.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2,
      S_HALT = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_TARGET = 2'd1,
      SEL_LINK   = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-address arithmetic: sequential PC and sign-extended, shifted offset target.
module pc_target_calc #(
   parameter int unsigned PC_W         = 32,
   parameter int unsigned OFFSET_W     = 8,
   parameter int unsigned OFFSET_SHIFT = 2,
   parameter int unsigned INSTR_BYTES  = 4
) (
   input  logic [PC_W-1:0]     pc_i,
   input  logic [OFFSET_W-1:0] offset_i,
   output logic [PC_W-1:0]     seq_c,
   output logic [PC_W-1:0]     target_c
);

   logic [PC_W-1:0] offset_sext;

   // All sums wrap modulo 2^PC_W; a negative offset below zero lands at the top of memory.
   always_comb begin
      offset_sext = PC_W'($signed(offset_i));
      seq_c       = pc_i + PC_W'(INSTR_BYTES);
      target_c    = seq_c + (offset_sext << OFFSET_SHIFT);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake FSM, PC register and saturating retire counter.
// Optional call/return link register is enabled with the PC_LINK_EN macro.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned   PC_W         = 32,
   parameter int unsigned   OFFSET_W     = 8,
   parameter int unsigned   OFFSET_SHIFT = 2,
   parameter int unsigned   INSTR_BYTES  = 4,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter int unsigned   CNT_W        = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                IMEM_READY,
   input  logic                JUMP,
   input  logic                BRANCH_EQ,
   input  logic                BRANCH_NE,
   input  logic                ZERO,
   input  logic [OFFSET_W-1:0] OFFSET,
   input  logic                HALT,
   output logic [PC_W-1:0]     PC,
   output logic                PC_VALID,
   output logic                EXEC,
   output logic                HALTED,
   output logic [CNT_W-1:0]    RETIRED
`ifdef PC_LINK_EN
   ,
   input  logic                CALL,
   input  logic                RET,
   output logic [PC_W-1:0]     LINK
`endif
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             pc_valid_q, pc_valid_d;
   logic             exec_q, exec_d;
   logic             halted_q, halted_d;
`ifdef PC_LINK_EN
   logic [PC_W-1:0]  link_q, link_d;
`endif

   logic [PC_W-1:0]  seq_c;
   logic [PC_W-1:0]  target_c;
   logic             taken;
   pc_sel_e          pc_sel;

   pc_target_calc #(
      .PC_W         (PC_W),
      .OFFSET_W     (OFFSET_W),
      .OFFSET_SHIFT (OFFSET_SHIFT),
      .INSTR_BYTES  (INSTR_BYTES)
   ) u_target_calc (
      .pc_i     (pc_q),
      .offset_i (OFFSET),
      .seq_c    (seq_c),
      .target_c (target_c)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
`ifdef PC_LINK_EN
      link_d    = link_q;
`endif
      // Asserting both branch flavours makes the branch unconditional.
      taken  = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
      pc_sel = taken ? SEL_TARGET : SEL_SEQ;
`ifdef PC_LINK_EN
      if (RET)       pc_sel = SEL_LINK;
      else if (CALL) pc_sel = SEL_TARGET;
`endif

      case (state_q)
         S_RST:  state_d = S_REQ;
         S_REQ:  if (IMEM_READY) state_d = S_EXEC;
         S_EXEC: begin
            retired_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
            if (HALT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_REQ;
               case (pc_sel)
                  SEL_TARGET: pc_d = target_c;
`ifdef PC_LINK_EN
                  SEL_LINK:   pc_d = link_q;
`endif
                  default:    pc_d = seq_c;
               endcase
`ifdef PC_LINK_EN
               if (CALL && !RET) link_d = seq_c;
`endif
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase

      pc_valid_d = (state_d == S_REQ);
      exec_d     = (state_d == S_EXEC);
      halted_d   = (state_d == S_HALT);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q    <= S_RST;
         pc_q       <= RESET_PC;
         retired_q  <= '0;
         pc_valid_q <= 1'b0;
         exec_q     <= 1'b0;
         halted_q   <= 1'b0;
`ifdef PC_LINK_EN
         link_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         retired_q  <= retired_d;
         pc_valid_q <= pc_valid_d;
         exec_q     <= exec_d;
         halted_q   <= halted_d;
`ifdef PC_LINK_EN
         link_q     <= link_d;
`endif
      end
   end

   assign PC       = pc_q;
   assign PC_VALID = pc_valid_q;
   assign EXEC     = exec_q;
   assign HALTED   = halted_q;
   assign RETIRED  = retired_q;
`ifdef PC_LINK_EN
   assign LINK     = link_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an instruction-level reference model.
// Covers the PC_LINK_EN call/return ports when that macro is defined.
module tb_pc_sequencer;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned CNT_W   = 8;
   localparam int          RET_MAX = (1 << CNT_W) - 1;
   localparam logic [31:0] RST_PC  = 32'h0;

   logic              CLK = 1'b0;
   logic              RESET, IMEM_READY, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, HALT;
   logic [7:0]        OFFSET;
   logic [PC_W-1:0]   PC;
   logic              PC_VALID, EXEC, HALTED;
   logic [CNT_W-1:0]  RETIRED;
`ifdef PC_LINK_EN
   logic              CALL, RET;
   logic [PC_W-1:0]   LINK;
`endif

   always #5 CLK = ~CLK;

   pc_sequencer #(
      .PC_W     (PC_W),
      .RESET_PC (RST_PC),
      .CNT_W    (CNT_W)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .IMEM_READY (IMEM_READY),
      .JUMP       (JUMP),
      .BRANCH_EQ  (BRANCH_EQ),
      .BRANCH_NE  (BRANCH_NE),
      .ZERO       (ZERO),
      .OFFSET     (OFFSET),
      .HALT       (HALT),
      .PC         (PC),
      .PC_VALID   (PC_VALID),
      .EXEC       (EXEC),
      .HALTED     (HALTED),
`ifdef PC_LINK_EN
      .CALL       (CALL),
      .RET        (RET),
      .LINK       (LINK),
`endif
      .RETIRED    (RETIRED)
   );

   int          n_tests = 0;
   int          n_fail  = 0;

   // Architectural model state, advanced once per executed instruction.
   logic [31:0] m_pc;
   logic [31:0] m_link;
   int          m_ret;
   bit          m_halted;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic junk_ctrl();
      JUMP      = 1'($urandom);
      BRANCH_EQ = 1'($urandom);
      BRANCH_NE = 1'($urandom);
      ZERO      = 1'($urandom);
      HALT      = 1'($urandom);
      OFFSET    = 8'($urandom);
`ifdef PC_LINK_EN
      CALL      = 1'($urandom);
      RET       = 1'($urandom);
`endif
   endtask

   task automatic chk_state(input string tag, input bit req, input bit ex);
      chk({tag, "_pc"},      64'(PC),       64'(m_pc));
      chk({tag, "_valid"},   64'(PC_VALID), 64'(req));
      chk({tag, "_exec"},    64'(EXEC),     64'(ex));
      chk({tag, "_halted"},  64'(HALTED),   64'(m_halted));
      chk({tag, "_retired"}, 64'(RETIRED),  64'(m_ret));
`ifdef PC_LINK_EN
      chk({tag, "_link"},    64'(LINK),     64'(m_link));
`endif
   endtask

   task automatic do_reset(input int n, input bit rdy);
      RESET      = 1'b0;
      IMEM_READY = rdy;
      junk_ctrl();
      m_pc = RST_PC; m_link = '0; m_ret = 0; m_halted = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk_state("rst", 1'b0, 1'b0);
         IMEM_READY = 1'($urandom);
         junk_ctrl();
      end
      RESET = 1'b1;
      @(negedge CLK);
      chk_state("rst_exit", 1'b1, 1'b0);
   endtask

   task automatic do_instr(input int stall, input bit j, input bit beq, input bit bne,
                           input bit z, input logic [7:0] off, input bit h,
                           input bit c, input bit r);
      logic [31:0] seq, tgt;
      int          soff;
      for (int i = 0; i < stall; i++) begin
         IMEM_READY = 1'b0;
         junk_ctrl();
         @(negedge CLK);
         chk_state("stall", 1'b1, 1'b0);
      end
      IMEM_READY = 1'b1;
      junk_ctrl();
      @(negedge CLK);
      chk_state("exec", 1'b0, 1'b1);
      IMEM_READY = 1'($urandom);
      JUMP = j; BRANCH_EQ = beq; BRANCH_NE = bne; ZERO = z; OFFSET = off; HALT = h;
`ifdef PC_LINK_EN
      CALL = c; RET = r;
`endif
      soff  = int'($signed(off));
      seq   = m_pc + 32'd4;
      tgt   = seq + 32'(soff * 4);
      m_ret = (m_ret < RET_MAX) ? m_ret + 1 : RET_MAX;
      if (h) m_halted = 1'b1;
`ifdef PC_LINK_EN
      else if (r) m_pc = m_link;
      else if (c) begin m_link = seq; m_pc = tgt; end
`endif
      else if (j || (beq && z) || (bne && !z)) m_pc = tgt;
      else m_pc = seq;
      @(negedge CLK);
      if (m_halted) chk_state("halt", 1'b0, 1'b0);
      else          chk_state("next", 1'b1, 1'b0);
   endtask

   task automatic halt_hold(input int n);
      for (int i = 0; i < n; i++) begin
         IMEM_READY = 1'($urandom);
         junk_ctrl();
         @(negedge CLK);
         chk_state("halted", 1'b0, 1'b0);
      end
   endtask

   initial begin
      RESET = 1'b0; IMEM_READY = 1'b0; JUMP = 1'b0; BRANCH_EQ = 1'b0; BRANCH_NE = 1'b0;
      ZERO = 1'b0; HALT = 1'b0; OFFSET = 8'h00;
`ifdef PC_LINK_EN
      CALL = 1'b0; RET = 1'b0;
`endif
      do_reset(2, 1'b0);

      // Stalled first fetch, then straight-line code.
      do_instr(3, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      do_instr(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      do_instr(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      chk("seq3_pc", 64'(PC), 64'h0C);
      chk("seq3_retired", 64'(RETIRED), 64'd3);

      // Branch variants from 0x10 with offset -2 words.
      do_instr(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      do_instr(1, 0, 1, 0, 1, 8'hFE, 0, 0, 0);
      chk("beq_taken", 64'(PC), 64'h0C);
      do_instr(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      do_instr(0, 0, 1, 0, 0, 8'hFE, 0, 0, 0);
      chk("beq_not_taken", 64'(PC), 64'h14);
      do_instr(0, 1, 0, 0, 0, 8'hFE, 0, 0, 0);
      do_instr(0, 0, 0, 1, 0, 8'hFE, 0, 0, 0);
      chk("bne_taken", 64'(PC), 64'h0C);
      do_instr(0, 1, 0, 0, 0, 8'h04, 0, 0, 0);
      do_instr(2, 1, 1, 0, 0, 8'h03, 0, 0, 0);
      chk("jump_over_branch", 64'(PC), 64'h30);
      do_instr(0, 0, 1, 1, 1, 8'h01, 0, 0, 0);
      do_instr(0, 0, 1, 1, 0, 8'h01, 0, 0, 0);

      // Wrap below zero.
      do_reset(1, 1'b1);
      do_instr(0, 1, 0, 0, 0, 8'h80, 0, 0, 0);
      chk("wrap_pc", 64'(PC), 64'hFFFFFE04);

`ifdef PC_LINK_EN
      do_reset(1, 1'b0);
      do_instr(0, 1, 0, 0, 0, 8'h0F, 0, 0, 0);
      do_instr(0, 1, 0, 0, 0, 8'h10, 0, 1, 0);
      chk("call_pc", 64'(PC), 64'h84);
      chk("call_link", 64'(LINK), 64'h44);
      do_instr(0, 1, 0, 0, 0, 8'h10, 0, 0, 1);
      chk("ret_pc", 64'(PC), 64'h44);
      do_instr(0, 0, 0, 0, 0, 8'h22, 0, 1, 1);
      chk("call_ret_link", 64'(LINK), 64'h44);
`endif

      // Random instruction stream; long enough to saturate the retire counter.
      for (int i = 0; i < 400; i++) begin
         do_instr($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom), 1'b0,
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      end
      chk("retired_sat", 64'(RETIRED), 64'(RET_MAX));

      // Halt freezes everything until reset.
      do_instr(1, 1, 0, 0, 0, 8'h11, 1, 0, 0);
      halt_hold(10);
      do_reset(1, 1'b1);
      chk("post_halt_pc", 64'(PC), 64'(RST_PC));

      // Reset asserted mid-request with memory ready overrides the fetch.
      for (int i = 0; i < 5; i++)
         do_instr($urandom_range(0, 1), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      IMEM_READY = 1'b0;
      junk_ctrl();
      @(negedge CLK);
      chk_state("pre_rst_req", 1'b1, 1'b0);
      do_reset(1, 1'b1);
      do_instr(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
